// File: rtl/motoro3_pwm_meter_pkg.sv
// Shared definitions for the motor PWM meter.
// Holds the 2-bit FSM state encoding and the default counter / filter sizes
// that the PWM generator and its self-test logic also rely on.
package motoro3_pwm_meter_pkg;

    localparam int CNT_W_DEF    = 13;
    localparam int FILT_LEN_DEF = 2;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } meter_state_e;

endpackage

// File: rtl/motoro3_pwm_meter_in_filter.sv
// Input conditioning for the PWM meter: 2-flop synchronizer followed by a
// run-length filter. The filtered level only follows the pin after FILT_LEN
// consecutive synchronized samples disagree with it, so shorter pulses vanish.
// Both edges see the same latency (2 + FILT_LEN cycles), keeping widths exact.
// Ports:
//   clk      in   system clock
//   nRst     in   asynchronous active-low reset
//   pwm_i    in   raw asynchronous PWM line
//   level_o  out  filtered level
//   rise_o   out  one-cycle pulse in the first cycle of a filtered high
//   fall_o   out  one-cycle pulse in the first cycle of a filtered low
module motoro3_pwm_meter_in_filter #(
    parameter int FILT_LEN = 2
) (
    input  logic clk,
    input  logic nRst,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [2:0] run_q;
    logic [2:0] run_d;
    logic       level_q;
    logic       level_d;
    logic       rise_q;
    logic       fall_q;

    // run_q counts how many consecutive samples have disagreed so far; the
    // level flips on the FILT_LEN-th disagreeing sample.
    always_comb begin
        run_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (run_q == 3'(FILT_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                run_d = run_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            run_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            run_q   <= run_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/motoro3_pwm_meter.sv
// Receive-side PWM meter: measures high and low time of one PWM line in clk
// cycles and publishes one high/low pair per complete period, plus stuck flags
// when a level outlasts the counter range.
// Ports:
//   clk        in   system clock (10 MHz)
//   nRst       in   asynchronous active-low reset
//   pwmIn      in   asynchronous PWM line under measurement
//   clr        in   synchronous clear: abandon current period, clear flags
//   measHigh   out  high cycles of the last complete period
//   measLow    out  low cycles of the last complete period
//   measValid  out  one-cycle pulse when measHigh/measLow update
//   stuckHigh  out  high level saturated the counter (sticky)
//   stuckLow   out  low level saturated the counter (sticky)
module motoro3_pwm_meter
    import motoro3_pwm_meter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             pwmIn,
    input  logic             clr,
    output logic [CNT_W-1:0] measHigh,
    output logic [CNT_W-1:0] measLow,
    output logic             measValid,
    output logic             stuckHigh,
    output logic             stuckLow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             level;
    logic             rise;
    logic             fall;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cntSat;

    meter_state_e     state_q;
    logic [CNT_W-1:0] hiHold_q;
    logic [CNT_W-1:0] measHigh_q;
    logic [CNT_W-1:0] measLow_q;
    logic             measValid_q;
    logic             stuckHigh_q;
    logic             stuckLow_q;

    motoro3_pwm_meter_in_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk     (clk),
        .nRst    (nRst),
        .pwm_i   (pwmIn),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Level-length counter: restarts at 1 on every filtered edge and sticks
    // at all-ones, so its value on the next edge pulse is the level width.
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cntSat = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Measurement FSM. A period is reported only when a full high followed
    // by a full low has been seen since SYNC; clr overrides any pending
    // report in the same cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_SYNC;
            hiHold_q    <= '0;
            measHigh_q  <= '0;
            measLow_q   <= '0;
            measValid_q <= 1'b0;
            stuckHigh_q <= 1'b0;
            stuckLow_q  <= 1'b0;
        end else begin
            measValid_q <= 1'b0;
            if (clr) begin
                state_q     <= ST_SYNC;
                hiHold_q    <= '0;
                stuckHigh_q <= 1'b0;
                stuckLow_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (rise) begin
                            state_q <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            hiHold_q <= cnt_q;
                            state_q  <= ST_LOW;
                        end else if (cntSat) begin
                            // level is high here; it selects the flag
                            stuckHigh_q <= level;
                            stuckLow_q  <= ~level;
                            state_q     <= ST_STUCK;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            measHigh_q  <= hiHold_q;
                            measLow_q   <= cnt_q;
                            measValid_q <= 1'b1;
                            state_q     <= ST_HIGH;
                        end else if (cntSat) begin
                            stuckHigh_q <= level;
                            stuckLow_q  <= ~level;
                            state_q     <= ST_STUCK;
                        end
                    end
                    ST_STUCK: begin
                        if (rise) begin
                            stuckHigh_q <= 1'b0;
                            stuckLow_q  <= 1'b0;
                            state_q     <= ST_HIGH;
                        end else if (fall) begin
                            stuckHigh_q <= 1'b0;
                            stuckLow_q  <= 1'b0;
                            state_q     <= ST_SYNC;
                        end
                    end
                    default: begin
                        state_q <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign measHigh  = measHigh_q;
    assign measLow   = measLow_q;
    assign measValid = measValid_q;
    assign stuckHigh = stuckHigh_q;
    assign stuckLow  = stuckLow_q;

endmodule
